// File: rtl/sevenseg_scan_reader_if.sv
// Display read-back bus: raw seven-segment/anode lines in, recovered digit state out.
// The display side (master) drives the bus; the reader (slave) decodes it.
interface sevenseg_scan_reader_if #(
    parameter int NUM_DIGITS = 4,
    parameter int WIDTH      = 3
);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    logic [6:0]                  seg_in;
    logic [NUM_DIGITS-1:0]       an_in;
    logic [NUM_DIGITS*WIDTH-1:0] digit_values;
    logic [NUM_DIGITS-1:0]       digit_valid;
    logic [NUM_DIGITS-1:0]       digit_err;
    logic                        update;
    logic [IDX_W-1:0]            update_idx;
    logic                        collision;
    logic                        frame_done;

    modport master (
        output seg_in,
        output an_in,
        input  digit_values,
        input  digit_valid,
        input  digit_err,
        input  update,
        input  update_idx,
        input  collision,
        input  frame_done
    );

    modport slave (
        input  seg_in,
        input  an_in,
        output digit_values,
        output digit_valid,
        output digit_err,
        output update,
        output update_idx,
        output collision,
        output frame_done
    );
endinterface

// File: rtl/sevenseg_scan_reader.sv
// Seven-segment scan reader: samples a multiplexed active-low display bus,
// waits for a stable pattern on a single anode, then decodes the glyph back
// into a digit value. Tracks per-digit freshness, bad glyphs and anode collisions.
module sevenseg_scan_reader #(
    parameter int NUM_DIGITS     = 4,
    parameter int WIDTH          = 3,
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                 clk,
    input  logic                 reset,
    sevenseg_scan_reader_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int RUN_W = $clog2(STABLE_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [RUN_W-1:0] RUN_TARGET = RUN_W'(STABLE_CYCLES);
    localparam logic [RUN_W-1:0] RUN_ONE    = RUN_W'(1);
    localparam logic [RUN_W-1:0] RUN_ZERO   = RUN_W'(0);
    localparam logic [TO_W-1:0]  TO_LIMIT   = TO_W'(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0]  TO_NEAR    = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    typedef struct packed {
        logic       legal;
        logic       blank;
        logic [2:0] value;
    } glyph_t;

    typedef struct packed {
        logic             any_low;
        logic             multi_low;
        logic [IDX_W-1:0] idx;
    } anode_t;

    // Inverse of the value-to-segment decoder (segments g..a, active-low).
    function automatic glyph_t decode_glyph(input logic [6:0] seg);
        glyph_t g;
        g.legal = 1'b1;
        g.blank = 1'b0;
        g.value = 3'd0;
        case (seg)
            7'b1000000: g.value = 3'd0;
            7'b1111001: g.value = 3'd1;
            7'b0100100: g.value = 3'd2;
            7'b0110000: g.value = 3'd3;
            7'b0011001: g.value = 3'd4;
            7'b0010010: g.value = 3'd5;
            7'b0000010: g.value = 3'd6;
            7'b1111000: g.value = 3'd7;
            7'b1111111: begin
                g.legal = 1'b0;
                g.blank = 1'b1;
            end
            default:    g.legal = 1'b0;
        endcase
        return g;
    endfunction

    // Classifies the anode lines: none low, exactly one low (with its index), or several low.
    function automatic anode_t scan_anodes(input logic [NUM_DIGITS-1:0] an);
        anode_t a;
        a.any_low   = 1'b0;
        a.multi_low = 1'b0;
        a.idx       = IDX_W'(0);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            a.multi_low = a.multi_low | (a.any_low & ~an[i]);
            a.idx       = (!an[i] && !a.any_low) ? IDX_W'(i) : a.idx;
            a.any_low   = a.any_low | ~an[i];
        end
        return a;
    endfunction

    logic [6:0]                  s_seg_r;
    logic [6:0]                  prev_seg_r;
    logic [NUM_DIGITS-1:0]       s_an_r;
    logic [NUM_DIGITS-1:0]       prev_an_r;
    state_t                      state_r;
    state_t                      state_next_s;
    logic [RUN_W-1:0]            run_r;
    logic [RUN_W-1:0]            run_next_s;
    logic                        same_s;
    logic                        eval_s;
    logic                        capture_s;
    logic                        collide_s;
    anode_t                      an_s;
    glyph_t                      glyph_s;
    logic [NUM_DIGITS*WIDTH-1:0] values_r;
    logic [NUM_DIGITS-1:0]       valid_r;
    logic [NUM_DIGITS-1:0]       err_r;
    logic [NUM_DIGITS-1:0]       mask_r;
    logic [NUM_DIGITS-1:0]       mask_next_s;
    logic [NUM_DIGITS-1:0]       cap_hit_s;
    logic [NUM_DIGITS-1:0]       to_expire_s;
    logic [TO_W-1:0]             to_cnt_r [NUM_DIGITS];
    logic                        update_r;
    logic [IDX_W-1:0]            update_idx_r;
    logic                        collision_r;
    logic                        frame_done_r;

    assign an_s    = scan_anodes(s_an_r);
    assign glyph_s = decode_glyph(s_seg_r);
    assign same_s  = (s_an_r == prev_an_r) && (s_seg_r == prev_seg_r);

    // Input register plus one-sample history used for stability comparison.
    always_ff @(posedge clk) begin
        if (reset) begin
            s_seg_r    <= 7'h7F;
            s_an_r     <= {NUM_DIGITS{1'b1}};
            prev_seg_r <= 7'h7F;
            prev_an_r  <= {NUM_DIGITS{1'b1}};
        end else begin
            s_seg_r    <= bus.seg_in;
            s_an_r     <= bus.an_in;
            prev_seg_r <= s_seg_r;
            prev_an_r  <= s_an_r;
        end
    end

    // Scan FSM next state: counts stable samples, decides capture and collision.
    // A changed sample in SETTLE/HOLD is re-evaluated like IDLE on the same edge.
    always_comb begin
        state_next_s = state_r;
        run_next_s   = run_r;
        capture_s    = 1'b0;
        collide_s    = 1'b0;
        eval_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                eval_s = 1'b1;
            end
            ST_SETTLE: begin
                if (same_s) begin
                    run_next_s = (run_r == RUN_TARGET) ? run_r : run_r + RUN_ONE;
                    if (run_next_s == RUN_TARGET) begin
                        capture_s    = 1'b1;
                        state_next_s = ST_HOLD;
                    end else begin
                        state_next_s = ST_SETTLE;
                    end
                end else begin
                    eval_s = 1'b1;
                end
            end
            ST_HOLD: begin
                if (same_s) begin
                    state_next_s = ST_HOLD;
                end else begin
                    eval_s = 1'b1;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                run_next_s   = RUN_ZERO;
            end
        endcase
        if (eval_s) begin
            if (an_s.multi_low) begin
                collide_s    = 1'b1;
                state_next_s = ST_IDLE;
                run_next_s   = RUN_ZERO;
            end else if (an_s.any_low) begin
                run_next_s = RUN_ONE;
                if (RUN_ONE == RUN_TARGET) begin
                    capture_s    = 1'b1;
                    state_next_s = ST_HOLD;
                end else begin
                    state_next_s = ST_SETTLE;
                end
            end else begin
                state_next_s = ST_IDLE;
                run_next_s   = RUN_ZERO;
            end
        end else begin
            collide_s = 1'b0;
        end
    end

    // FSM state and stable-run counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            run_r   <= RUN_ZERO;
        end else begin
            state_r <= state_next_s;
            run_r   <= run_next_s;
        end
    end

    // Per-digit capture strobes, timeout expiry and next frame mask.
    always_comb begin
        cap_hit_s   = {NUM_DIGITS{1'b0}};
        to_expire_s = {NUM_DIGITS{1'b0}};
        mask_next_s = {NUM_DIGITS{1'b0}};
        for (int i = 0; i < NUM_DIGITS; i++) begin
            cap_hit_s[i]   = capture_s && (an_s.idx == IDX_W'(i));
            to_expire_s[i] = (to_cnt_r[i] >= TO_NEAR);
            mask_next_s[i] = mask_r[i] | cap_hit_s[i];
        end
    end

    // Digit value/valid/error storage and freshness counters; capture beats timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            values_r <= {(NUM_DIGITS*WIDTH){1'b0}};
            valid_r  <= {NUM_DIGITS{1'b0}};
            err_r    <= {NUM_DIGITS{1'b0}};
            for (int i = 0; i < NUM_DIGITS; i++) begin
                to_cnt_r[i] <= TO_W'(0);
            end
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (cap_hit_s[i]) begin
                    to_cnt_r[i] <= TO_W'(0);
                    if (glyph_s.legal) begin
                        values_r[i*WIDTH +: WIDTH] <= WIDTH'(glyph_s.value);
                        valid_r[i]                 <= 1'b1;
                        err_r[i]                   <= 1'b0;
                    end else begin
                        valid_r[i] <= 1'b0;
                        err_r[i]   <= ~glyph_s.blank;
                    end
                end else begin
                    to_cnt_r[i] <= (to_cnt_r[i] == TO_LIMIT) ? to_cnt_r[i] : to_cnt_r[i] + TO_W'(1);
                    valid_r[i]  <= valid_r[i] & ~to_expire_s[i];
                end
            end
        end
    end

    // Event pulses and the frame mask that tracks which digits were seen this frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            update_r     <= 1'b0;
            update_idx_r <= IDX_W'(0);
            collision_r  <= 1'b0;
            frame_done_r <= 1'b0;
            mask_r       <= {NUM_DIGITS{1'b0}};
        end else begin
            update_r     <= capture_s;
            update_idx_r <= capture_s ? an_s.idx : update_idx_r;
            collision_r  <= collide_s;
            frame_done_r <= capture_s & (&mask_next_s);
            mask_r       <= (&mask_next_s) ? {NUM_DIGITS{1'b0}} : mask_next_s;
        end
    end

    assign bus.digit_values = values_r;
    assign bus.digit_valid  = valid_r;
    assign bus.digit_err    = err_r;
    assign bus.update       = update_r;
    assign bus.update_idx   = update_idx_r;
    assign bus.collision    = collision_r;
    assign bus.frame_done   = frame_done_r;
endmodule
